// File: rtl/ascon_pkg.sv
// Shared types for the Ascon stream bridge: FSM state encodings and word width.
package ascon_pkg;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IN_IDLE, IN_FILL, IN_LAUNCH, IN_WAIT_REQ, IN_REFILL, IN_SIGNAL, IN_WAIT_DROP
    } in_state_t;

    typedef enum logic [2:0] {
        OUT_IDLE, OUT_DRAIN, OUT_ACK, OUT_WAIT_LOW, OUT_TAIL, OUT_TAG
    } out_state_t;
endpackage

// File: rtl/ascon_word_packer.sv
// Pairs 32-bit host words into 64-bit entries; strobes once per completed pair.
module ascon_word_packer import ascon_pkg::*; (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                clr_i,
    input  logic                word_vld_i,
    input  logic [WORD_W-1:0]   word_i,
    output logic                entry_we_o,
    output logic [2*WORD_W-1:0] entry_o
);
    logic              half_q;
    logic [WORD_W-1:0] lo_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            half_q <= 1'b0;
            lo_q   <= '0;
        end else if (clr_i) begin
            half_q <= 1'b0;
        end else if (word_vld_i) begin
            half_q <= ~half_q;
            if (!half_q) lo_q <= word_i;
        end
    end

    assign entry_we_o = word_vld_i & half_q;
    assign entry_o    = {word_i, lo_q};
endmodule

// File: rtl/ascon_stream_bridge.sv
// Bridges a 32-bit host stream to the block-buffered Ascon core: input side packs
// AD/PT into the core's buffer, output side drains ciphertext and appends the tag.
module ascon_stream_bridge import ascon_pkg::*; #(
    parameter int BUF_DEPTH = 4,
    parameter int BLK_AD_AW = 3,
    parameter int BLK_PT_AW = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          start_i,
    input  logic [BLK_AD_AW-1:0]          ad_size_i,
    input  logic [BLK_PT_AW-1:0]          pt_size_i,
    input  logic [WORD_W-1:0]             in_data_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    output logic [WORD_W-1:0]             out_data_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic                          out_last_o,
    output logic                          ascon_start_o,
    output logic [BUF_DEPTH-1:0][63:0]    data_o,
    input  logic                          data_req_i,
    output logic                          data_valid_o,
    input  logic [BUF_DEPTH-1:0][63:0]    ct_i,
    input  logic                          ct_ready_i,
    output logic                          ct_read_ack_o,
    input  logic                          done_i,
    input  logic [127:0]                  tag_i
);
    localparam int IDX_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int E_W    = IDX_W + 1;
    localparam int REM_W  = ((BLK_AD_AW > BLK_PT_AW) ? BLK_AD_AW : BLK_PT_AW) + 1;
    localparam int DRN_W  = REM_W + 1;
    localparam int WIDX_W = IDX_W + 2;

    // ---------------- input side ----------------
    in_state_t             in_q, in_nxt;
    logic [E_W-1:0]        e_q, e_inc;
    logic [REM_W-1:0]      rem_q, rem_dec;
    logic [BLK_PT_AW-1:0]  pt_q;
    logic                  in_done_q;
    logic                  entry_we, fill_end;
    logic [63:0]           entry;

    ascon_word_packer u_packer (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .clr_i      (~in_ready_o),
        .word_vld_i (in_valid_i & in_ready_o),
        .word_i     (in_data_i),
        .entry_we_o (entry_we),
        .entry_o    (entry)
    );

    assign e_inc    = e_q + 1'b1;
    assign rem_dec  = rem_q - 1'b1;
    assign fill_end = entry_we && (e_inc == E_W'(BUF_DEPTH) || rem_dec == '0);

    always_comb begin
        in_nxt        = in_q;
        in_ready_o    = 1'b0;
        ascon_start_o = 1'b0;
        data_valid_o  = 1'b0;
        case (in_q)
            IN_IDLE:      if (start_i && pt_size_i != '0) in_nxt = IN_FILL;
            IN_FILL: begin
                in_ready_o = 1'b1;
                if (fill_end) in_nxt = IN_LAUNCH;
            end
            IN_LAUNCH: begin
                ascon_start_o = 1'b1;
                in_nxt        = IN_WAIT_REQ;
            end
            IN_WAIT_REQ: begin
                if (rem_q != '0) begin
                    if (data_req_i) in_nxt = IN_REFILL;
                end else if (in_done_q) begin
                    in_nxt = IN_IDLE;
                end
            end
            IN_REFILL: begin
                in_ready_o = 1'b1;
                if (fill_end) in_nxt = IN_SIGNAL;
            end
            IN_SIGNAL: begin
                data_valid_o = 1'b1;
                in_nxt       = IN_WAIT_DROP;
            end
            // A request still held high after the refill must not start another one.
            IN_WAIT_DROP: if (!data_req_i) in_nxt = IN_WAIT_REQ;
            default:      in_nxt = IN_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            in_q      <= IN_IDLE;
            e_q       <= '0;
            rem_q     <= '0;
            pt_q      <= '0;
            in_done_q <= 1'b0;
            data_o    <= '0;
        end else begin
            in_q <= in_nxt;
            if (done_i) in_done_q <= 1'b1;
            if (in_q == IN_IDLE && in_nxt == IN_FILL) begin
                pt_q      <= pt_size_i;
                rem_q     <= REM_W'(ad_size_i) + REM_W'(pt_size_i);
                e_q       <= '0;
                data_o    <= '0;
                in_done_q <= 1'b0;
            end
            if (in_q == IN_WAIT_REQ && in_nxt == IN_REFILL) begin
                e_q    <= '0;
                data_o <= '0;
            end
            if (in_q == IN_WAIT_REQ && in_nxt == IN_IDLE) in_done_q <= 1'b0;
            if (entry_we) begin
                data_o[e_q[IDX_W-1:0]] <= entry;
                e_q                    <= e_inc;
                rem_q                  <= rem_dec;
            end
        end
    end

    // ---------------- output side ----------------
    out_state_t            out_q, out_nxt;
    logic [WIDX_W-1:0]     widx_q, tail_words_q;
    logic [DRN_W-1:0]      drained_q, tail_blk;
    logic                  done_q;
    logic                  out_valid_q, out_last_q;
    logic [WORD_W-1:0]     out_data_q;
    logic                  slot_free, ld, ld_last;
    logic [WORD_W-1:0]     ld_word;
    logic [1:0][WORD_W-1:0] ct_pair;
    logic [3:0][WORD_W-1:0] tag_w;

    assign slot_free = !out_valid_q || out_ready_i;
    assign ct_pair   = ct_i[widx_q[IDX_W:1]];
    assign tag_w     = tag_i;

    // Blocks still owed after the full-buffer drains, never more than one buffer.
    always_comb begin
        tail_blk = '0;
        if (DRN_W'(pt_q) > drained_q) begin
            tail_blk = DRN_W'(pt_q) - drained_q;
            if (tail_blk > DRN_W'(BUF_DEPTH)) tail_blk = DRN_W'(BUF_DEPTH);
        end
    end

    always_comb begin
        out_nxt       = out_q;
        ld            = 1'b0;
        ld_word       = ct_pair[widx_q[0]];
        ld_last       = 1'b0;
        ct_read_ack_o = 1'b0;
        case (out_q)
            OUT_IDLE: begin
                if (ct_ready_i)  out_nxt = OUT_DRAIN;
                else if (done_q) out_nxt = (tail_blk != '0) ? OUT_TAIL : OUT_TAG;
            end
            OUT_DRAIN: begin
                if (widx_q != WIDX_W'(2*BUF_DEPTH)) ld = slot_free;
                else if (slot_free)                  out_nxt = OUT_ACK;
            end
            OUT_ACK: begin
                ct_read_ack_o = 1'b1;
                out_nxt       = OUT_WAIT_LOW;
            end
            OUT_WAIT_LOW: if (!ct_ready_i) out_nxt = OUT_IDLE;
            OUT_TAIL: begin
                if (widx_q != tail_words_q) ld = slot_free;
                else if (slot_free)         out_nxt = OUT_TAG;
            end
            OUT_TAG: begin
                ld_word = tag_w[widx_q[1:0]];
                ld_last = (widx_q == WIDX_W'(3));
                if (widx_q != WIDX_W'(4)) ld = slot_free;
                else if (slot_free)       out_nxt = OUT_IDLE;
            end
            default: out_nxt = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_q        <= OUT_IDLE;
            widx_q       <= '0;
            tail_words_q <= '0;
            drained_q    <= '0;
            done_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
        end else begin
            out_q <= out_nxt;
            if (out_nxt != out_q) widx_q <= '0;
            else if (ld)          widx_q <= widx_q + 1'b1;
            // Output register captures the word, so it holds through any stall.
            if (ld) begin
                out_data_q  <= ld_word;
                out_valid_q <= 1'b1;
                out_last_q  <= ld_last;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            if (out_q == OUT_IDLE && out_nxt == OUT_TAIL) tail_words_q <= WIDX_W'(tail_blk) << 1;
            if (out_q == OUT_ACK) drained_q <= drained_q + DRN_W'(BUF_DEPTH);
            if (out_q == OUT_TAG && out_nxt == OUT_IDLE) begin
                done_q    <= 1'b0;
                drained_q <= '0;
            end
            if (done_i) done_q <= 1'b1;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
endmodule
